// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU arbiter/controller.
package alu_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam int DATA_W = 6;
    localparam int OP_W   = 4;
    localparam int N_REQ  = 2;

    // ALU opcodes
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b0110;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_SAR  = 4'b1000;
    localparam logic [OP_W-1:0] OP_ROL  = 4'b1001;
    localparam logic [OP_W-1:0] OP_ROR  = 4'b1010;
    localparam logic [OP_W-1:0] OP_NEG  = 4'b1011;
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'b1100;

    // Opcode presented on the ALU port out of reset
    localparam logic [OP_W-1:0] OP_RESET = OP_XOR;

    // Bit positions inside the {Cf,Of,Zf,Sf} flag vector
    localparam int FLAG_SF = 0;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_CF = 3;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op < OP_ILLEGAL_MIN);
    endfunction

    // Keep only the flags that are meaningful for the opcode; the rest are forced to 0
    function automatic logic [3:0] mask_flags(input logic [OP_W-1:0] op,
                                              input logic cf, input logic of_f,
                                              input logic zf, input logic sf);
        logic [3:0] f;
        f = 4'b0000;
        f[FLAG_ZF] = zf;
        if ((op == OP_ADD) || (op == OP_SUB)) begin
            f[FLAG_SF] = sf;
            f[FLAG_OF] = of_f;
        end
        if (op == OP_ADD) begin
            f[FLAG_CF] = cf;
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin arbiter; pointer moves to the other requester on accept.
module alu_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection: favour the requester the pointer names, else the other one
    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (ptr_q == 1'b0) begin
                if (req_i[0])      grant_o = 2'b01;
                else if (req_i[1]) grant_o = 2'b10;
            end else begin
                if (req_i[1])      grant_o = 2'b10;
                else if (req_i[0]) grant_o = 2'b01;
            end
        end
    end

    // Pointer next state: after an accept, the other requester gets priority
    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = ~grant_o[1];
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Arbitrates two requesters onto a shared external ALU, waits SETTLE cycles,
// captures the masked result and returns it to the granted requester.
module alu_arb_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [11:0] req_a,
    input  logic [11:0] req_b,
    input  logic [7:0]  req_op,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [5:0]  rsp_out,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [5:0]  alu_a,
    output logic [5:0]  alu_b,
    output logic [3:0]  alu_op,
    input  logic [5:0]  alu_out,
    input  logic        alu_cf,
    input  logic        alu_of,
    input  logic        alu_zf,
    input  logic        alu_sf,
    output logic        busy
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               g_q;
    logic [DATA_W-1:0]  alu_a_q, alu_b_q;
    logic [OP_W-1:0]    alu_op_q;
    logic [DATA_W-1:0]  rsp_out_q;
    logic [3:0]         rsp_flags_q;
    logic               rsp_err_q;

    logic [DATA_W-1:0]  a_arr  [N_REQ];
    logic [DATA_W-1:0]  b_arr  [N_REQ];
    logic [OP_W-1:0]    op_arr [N_REQ];

    logic               arb_en;
    logic [1:0]         grant;
    logic               accept;
    logic               sel_idx;
    logic [DATA_W-1:0]  sel_a, sel_b;
    logic [OP_W-1:0]    sel_op;
    logic               sel_legal;
    logic               settle_done;
    logic               rsp_done;

    // Unpack the per-requester operand buses
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[DATA_W*gi +: DATA_W];
            assign b_arr[gi]  = req_b[DATA_W*gi +: DATA_W];
            assign op_arr[gi] = req_op[OP_W*gi +: OP_W];
        end
    endgenerate

    alu_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (arb_en),
        .req_i    (req_valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    assign req_ready   = grant;
    assign accept      = |(req_valid & grant);
    assign sel_idx     = grant[1];
    assign sel_a       = a_arr[sel_idx];
    assign sel_b       = b_arr[sel_idx];
    assign sel_op      = op_arr[sel_idx];
    assign sel_legal   = op_is_legal(sel_op);
    assign settle_done = (cnt_q == SETTLE_LAST);
    assign rsp_done    = rsp_ready[g_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; illegal opcodes skip the ALU entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)      state_d = sel_legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: if (settle_done) state_d = ST_RESP;
            ST_RESP:  if (rsp_done)    state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; grants are gated by reset so req_ready drops at once
    always_comb begin
        busy      = (state_q != ST_IDLE);
        arb_en    = (state_q == ST_IDLE) && rst_n;
        rsp_valid = 2'b00;
        if (state_q == ST_RESP) begin
            rsp_valid[g_q] = 1'b1;
        end
    end

    // Settle counter next value: counts ISSUE cycles, idles at 0
    always_comb begin
        cnt_d = 4'd0;
        if ((state_q == ST_ISSUE) && !settle_done) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Settle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 4'd0;
        else        cnt_q <= cnt_d;
    end

    // Request capture, ALU drive registers and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q         <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_RESET;
            rsp_out_q   <= '0;
            rsp_flags_q <= 4'b0000;
            rsp_err_q   <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && accept) begin
                g_q <= sel_idx;
                if (sel_legal) begin
                    alu_a_q  <= sel_a;
                    alu_b_q  <= sel_b;
                    alu_op_q <= sel_op;
                end else begin
                    rsp_out_q   <= '0;
                    rsp_flags_q <= 4'b0000;
                    rsp_err_q   <= 1'b1;
                end
            end
            if ((state_q == ST_ISSUE) && settle_done) begin
                rsp_out_q   <= alu_out;
                rsp_flags_q <= mask_flags(alu_op_q, alu_cf, alu_of, alu_zf, alu_sf);
                rsp_err_q   <= 1'b0;
            end
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed bench for alu_arb_ctrl: one instance with SETTLE=1, one with SETTLE=4.
module tb_alu_arb_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance 1 (SETTLE=1) ----------------
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [11:0] req_a, req_b;
    logic [7:0]  req_op;
    logic [5:0]  rsp_out, alu_a, alu_b, alu_out;
    logic [3:0]  rsp_flags, alu_op;
    logic        rsp_err, alu_cf, alu_of, alu_zf, alu_sf, busy;

    // ---------------- instance 2 (SETTLE=4) ----------------
    logic        rst2_n;
    logic [1:0]  v2, rdy2, rv2, rr2;
    logic [11:0] a2, b2;
    logic [7:0]  op2;
    logic [5:0]  out2, alu_a2, alu_b2, alu_out2;
    logic [3:0]  flags2, alu_op2;
    logic        err2, cf2, of2, zf2, sf2, busy2;

    // External ALU environment: returns {cf,of,zf,sf,out[5:0]}.
    // Non-arithmetic ops deliberately raise cf/of so masking is observable.
    function automatic logic [9:0] alu_env(input logic [5:0] a, input logic [5:0] b,
                                           input logic [3:0] op);
        logic [6:0] s;
        logic [5:0] r;
        logic c, o;
        case (op)
            4'b0000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[5:0]; c = s[6];
                o = (a[5] == b[5]) && (r[5] != a[5]);
            end
            4'b0001: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[5:0]; c = s[6];
                o = (a[5] != b[5]) && (r[5] != a[5]);
            end
            4'b0111: begin
                r = a >> 1; c = a[0]; o = 1'b1;
            end
            default: begin
                r = a ^ b; c = 1'b1; o = 1'b1;
            end
        endcase
        return {c, o, (r == 6'd0), r[5], r};
    endfunction

    assign {alu_cf, alu_of, alu_zf, alu_sf, alu_out} = alu_env(alu_a, alu_b, alu_op);
    assign {cf2, of2, zf2, sf2, alu_out2}            = alu_env(alu_a2, alu_b2, alu_op2);

    alu_arb_ctrl #(.SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_cf(alu_cf), .alu_of(alu_of),
        .alu_zf(alu_zf), .alu_sf(alu_sf), .busy(busy)
    );

    alu_arb_ctrl #(.SETTLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst2_n),
        .req_valid(v2), .req_ready(rdy2),
        .req_a(a2), .req_b(b2), .req_op(op2),
        .rsp_valid(rv2), .rsp_ready(rr2),
        .rsp_out(out2), .rsp_flags(flags2), .rsp_err(err2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2),
        .alu_out(alu_out2), .alu_cf(cf2), .alu_of(of2),
        .alu_zf(zf2), .alu_sf(sf2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected results for the alternating-grant test, indexed by requester
    logic [5:0] alt_out   [2];
    logic [3:0] alt_flags [2];

    initial begin
        alt_out[0] = 6'h06; alt_flags[0] = 4'b0000;
        alt_out[1] = 6'h00; alt_flags[1] = 4'b0010;

        rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
        req_a = '0; req_b = '0; req_op = '0;
        rst2_n = 1'b0; v2 = 2'b00; rr2 = 2'b00; a2 = '0; b2 = '0; op2 = '0;
        tick();

        // Reset values (requests pending during reset must not be granted)
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_out",   rsp_out,   6'h00);
        chk("rst_rsp_flags", rsp_flags, 4'h0);
        chk("rst_rsp_err",   rsp_err,   1'b0);
        chk("rst_alu_a",     alu_a,     6'h00);
        chk("rst_alu_b",     alu_b,     6'h00);
        chk("rst_alu_op",    alu_op,    4'b0100);
        chk("rst_busy",      busy,      1'b0);
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();

        // Basic add 5+3 on requester 0; latency 2 cycles for SETTLE=1
        req_a = {6'h00, 6'h05}; req_b = {6'h00, 6'h03}; req_op = 8'h00;
        req_valid = 2'b01;
        chk("add_req_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("add_issue_busy",  busy,      1'b1);
        chk("add_issue_valid", rsp_valid, 2'b00);
        chk("add_issue_alu_a", alu_a,     6'h05);
        chk("add_issue_alu_b", alu_b,     6'h03);
        tick();
        chk("add_rsp_valid", rsp_valid, 2'b01);
        chk("add_rsp_out",   rsp_out,   6'h08);
        chk("add_rsp_flags", rsp_flags, 4'h0);
        chk("add_rsp_err",   rsp_err,   1'b0);
        $display("txn add: req0 5+3 -> out=%0h flags=%0h", rsp_out, rsp_flags);

        // Response held while rsp_ready is low; pending request must not be granted
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid",     rsp_valid, 2'b01);
            chk("hold_out",       rsp_out,   6'h08);
            chk("hold_req_ready", req_ready, 2'b00);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tick();
        chk("add_done_busy",  busy,      1'b0);
        chk("add_done_valid", rsp_valid, 2'b00);

        // 0x20+0x20 wraps to zero with carry and signed overflow
        req_a = {6'h00, 6'h20}; req_b = {6'h00, 6'h20}; req_op = 8'h00;
        req_valid = 2'b01;
        chk("ovf_req_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        chk("ovf_rsp_valid", rsp_valid, 2'b01);
        chk("ovf_rsp_out",   rsp_out,   6'h00);
        chk("ovf_rsp_flags", rsp_flags, 4'b1110);
        $display("txn ovf: req0 20+20 -> out=%0h flags=%0h", rsp_out, rsp_flags);
        tick();

        // Fresh reset, then both requesters continuously valid: grants alternate
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        req_a = {6'h01, 6'h0C}; req_b = {6'h2A, 6'h15}; req_op = 8'h77;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            chk("alt_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("alt_issue_valid", rsp_valid, 2'b00);
            tick();
            chk("alt_rsp_valid", rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt_rsp_out",   rsp_out,   alt_out[i % 2]);
            chk("alt_rsp_flags", rsp_flags, alt_flags[i % 2]);
            chk("alt_resp_req_ready", req_ready, 2'b00);
            $display("txn alt %0d: rsp_valid=%b out=%0h flags=%0h", i, rsp_valid, rsp_out, rsp_flags);
            tick();
        end

        // Illegal opcode from requester 1: response next cycle, ALU untouched
        req_valid = 2'b10; rsp_ready = 2'b00;
        req_a = {6'h3F, 6'h00}; req_b = {6'h3F, 6'h00}; req_op = 8'hD0;
        chk("ill_req_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("ill_rsp_valid", rsp_valid, 2'b10);
        chk("ill_rsp_err",   rsp_err,   1'b1);
        chk("ill_rsp_out",   rsp_out,   6'h00);
        chk("ill_rsp_flags", rsp_flags, 4'h0);
        chk("ill_alu_a",     alu_a,     6'h01);
        chk("ill_alu_b",     alu_b,     6'h2A);
        chk("ill_alu_op",    alu_op,    4'b0111);
        $display("txn ill: req1 op=d -> err=%b out=%0h", rsp_err, rsp_out);

        // rsp_ready from the non-granted requester is ignored
        rsp_ready = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ill_ignore_valid", rsp_valid, 2'b10);
        end
        rsp_ready = 2'b10;
        tick();
        chk("ill_done_busy", busy, 1'b0);

        // SETTLE=4 instance: reset in the middle of ISSUE discards the request
        rst2_n = 1'b1;
        tick();
        a2 = {6'h00, 6'h01}; b2 = {6'h00, 6'h02}; op2 = 8'h00; v2 = 2'b01;
        chk("s4_first_ready", rdy2, 2'b01);
        tick();
        v2 = 2'b00;
        tick();
        chk("s4_mid_busy", busy2, 1'b1);
        v2 = 2'b11;
        #1 rst2_n = 1'b0;
        #1;
        chk("s4_rst_busy",   busy2,   1'b0);
        chk("s4_rst_ready",  rdy2,    2'b00);
        chk("s4_rst_valid",  rv2,     2'b00);
        chk("s4_rst_alu_a",  alu_a2,  6'h00);
        chk("s4_rst_alu_op", alu_op2, 4'b0100);
        tick();
        v2 = 2'b00;
        rst2_n = 1'b1;
        rr2 = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("s4_no_rsp", rv2, 2'b00);
        end

        // Next request served normally, requester 0 first, latency SETTLE+1
        a2 = {6'h03, 6'h07}; b2 = {6'h03, 6'h09}; op2 = 8'h00; v2 = 2'b11;
        chk("s4_prio0", rdy2, 2'b01);
        tick();
        v2 = 2'b00;
        chk("s4_issue_alu_a", alu_a2, 6'h07);
        for (int i = 0; i < 4; i++) begin
            chk("s4_settle_valid", rv2, 2'b00);
            tick();
        end
        chk("s4_rsp_valid", rv2,    2'b01);
        chk("s4_rsp_out",   out2,   6'h10);
        chk("s4_rsp_flags", flags2, 4'h0);
        $display("txn s4: req0 7+9 -> out=%0h flags=%0h", out2, flags2);
        tick();
        chk("s4_done_busy", busy2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
